// File: rtl/pond_arb_pkg.sv
// Shared types and default widths for the pond access arbiter.
package pond_arb_pkg;

    localparam int unsigned POND_DATA_W     = 16;
    localparam int unsigned POND_ADDR_W     = 5;
    localparam int unsigned POND_WBUF_DEPTH = 4;

    // One deferred write held in the write buffer.
    typedef struct packed {
        logic [POND_ADDR_W-1:0] addr;
        logic [POND_DATA_W-1:0] data;
    } wbuf_entry_t;

    // Who owns the SRAM port this cycle.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_READ   = 2'd1,
        ARB_DRAIN  = 2'd2,
        ARB_DIRECT = 2'd3
    } arb_t;

endpackage

// File: rtl/pond_access_arbiter_if.sv
// Accessor request/return and SRAM macro signals of the pond access arbiter.
interface pond_access_arbiter_if
    import pond_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = POND_DATA_W,
    parameter int unsigned ADDR_WIDTH = POND_ADDR_W
);

    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_valid;
    logic                  mem_cen;
    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_rdata,
        output rd_data, rd_data_valid, mem_cen, mem_wen, mem_addr, mem_wdata
    );

    // Accessor + SRAM side.
    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_rdata,
        input  rd_data, rd_data_valid, mem_cen, mem_wen, mem_addr, mem_wdata
    );

endinterface

// File: rtl/pond_wbuf.sv
// Ordered write buffer: FIFO drain plus youngest-entry address lookup for forwarding.
module pond_wbuf
    import pond_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = POND_WBUF_DEPTH,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  wbuf_entry_t            i_push_entry,
    input  logic [POND_ADDR_W-1:0] i_lookup_addr,
    output wbuf_entry_t            o_head,
    output logic                   o_empty,
    output logic                   o_drop,
    output logic                   o_hit,
    output logic [POND_DATA_W-1:0] o_hit_data,
    output logic [CW-1:0]          o_count
);

    localparam int unsigned PW = $clog2(DEPTH);

    wbuf_entry_t   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_do_pop;
    logic          w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_drop    = i_push && w_full && !w_do_pop;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_entry;
    end

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (r_mem[r_rd_ptr + PW'(i)].addr == i_lookup_addr)) begin
                o_hit      = 1'b1;
                o_hit_data = r_mem[r_rd_ptr + PW'(i)].data;
            end
        end
    end

endmodule

// File: rtl/pond_access_arbiter.sv
// Single-port pond SRAM arbiter: reads win, writes defer to a buffer, reads forward from it.
// Optional statistics counters: define POND_ACCESS_ARBITER_STATS_EN.
module pond_access_arbiter
    import pond_arb_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = POND_DATA_W,
    parameter  int unsigned ADDR_WIDTH = POND_ADDR_W,
    parameter  int unsigned WBUF_DEPTH = POND_WBUF_DEPTH,
    localparam int unsigned CW         = $clog2(WBUF_DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tile_en,
    pond_access_arbiter_if.slave        bus,
    output logic [CW-1:0]               wbuf_count,
`ifdef POND_ACCESS_ARBITER_STATS_EN
    output logic [15:0]                 stat_deferred_writes,
    output logic [15:0]                 stat_forwarded_reads,
`endif
    output logic                        overflow
);

    arb_t                   w_arb;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_empty;
    logic                   w_drop;
    logic                   w_hit;
    logic [POND_DATA_W-1:0] w_hit_data;
    wbuf_entry_t            w_head;
    wbuf_entry_t            w_push_entry;
    logic [DATA_WIDTH-1:0]  w_rd_data;

    logic                   r_rd_valid;
    logic                   r_rd_fwd;
    logic [DATA_WIDTH-1:0]  r_rd_fwd_data;
    logic [DATA_WIDTH-1:0]  r_rd_hold;
    logic                   r_overflow;

    // Port ownership; nothing is granted in reset or with the tile disabled.
    always_comb begin
        w_arb = ARB_IDLE;
        if (rst_n && tile_en) begin
            if (bus.rd_valid)      w_arb = ARB_READ;
            else if (!w_empty)     w_arb = ARB_DRAIN;
            else if (bus.wr_valid) w_arb = ARB_DIRECT;
        end
    end

    assign w_push       = bus.wr_valid && ((w_arb == ARB_READ) || (w_arb == ARB_DRAIN));
    assign w_pop        = (w_arb == ARB_DRAIN);
    assign w_push_entry = '{addr: POND_ADDR_W'(bus.wr_addr), data: POND_DATA_W'(bus.wr_data)};

    pond_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (w_push),
        .i_pop         (w_pop),
        .i_push_entry  (w_push_entry),
        .i_lookup_addr (POND_ADDR_W'(bus.rd_addr)),
        .o_head        (w_head),
        .o_empty       (w_empty),
        .o_drop        (w_drop),
        .o_hit         (w_hit),
        .o_hit_data    (w_hit_data),
        .o_count       (wbuf_count)
    );

    // SRAM port mux driven by the arbitration outcome.
    always_comb begin
        bus.mem_cen   = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (w_arb)
            ARB_READ: begin
                bus.mem_cen  = 1'b1;
                bus.mem_addr = bus.rd_addr;
            end
            ARB_DRAIN: begin
                bus.mem_cen   = 1'b1;
                bus.mem_wen   = 1'b1;
                bus.mem_addr  = ADDR_WIDTH'(w_head.addr);
                bus.mem_wdata = DATA_WIDTH'(w_head.data);
            end
            ARB_DIRECT: begin
                bus.mem_cen   = 1'b1;
                bus.mem_wen   = 1'b1;
                bus.mem_addr  = bus.wr_addr;
                bus.mem_wdata = bus.wr_data;
            end
            default: ;
        endcase
    end

    // SRAM data arrives the cycle after the access, so the return selects it live and holds it afterwards.
    assign w_rd_data         = r_rd_valid ? (r_rd_fwd ? r_rd_fwd_data : bus.mem_rdata) : r_rd_hold;
    assign bus.rd_data       = w_rd_data;
    assign bus.rd_data_valid = r_rd_valid;
    assign overflow          = r_overflow;

    // Read-return bookkeeping and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_valid    <= 1'b0;
            r_rd_fwd      <= 1'b0;
            r_rd_fwd_data <= '0;
            r_rd_hold     <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_rd_valid <= (w_arb == ARB_READ);
            if (w_arb == ARB_READ) begin
                r_rd_fwd      <= w_hit;
                r_rd_fwd_data <= DATA_WIDTH'(w_hit_data);
            end
            if (r_rd_valid) r_rd_hold <= w_rd_data;
            if (w_drop)     r_overflow <= 1'b1;
        end
    end

`ifdef POND_ACCESS_ARBITER_STATS_EN
    logic [15:0] r_stat_deferred;
    logic [15:0] r_stat_forwarded;

    // Saturating counters of buffered writes and forwarded reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_deferred  <= '0;
            r_stat_forwarded <= '0;
        end else begin
            if (w_push && !w_drop && (r_stat_deferred != 16'hFFFF))
                r_stat_deferred <= r_stat_deferred + 16'd1;
            if ((w_arb == ARB_READ) && w_hit && (r_stat_forwarded != 16'hFFFF))
                r_stat_forwarded <= r_stat_forwarded + 16'd1;
        end
    end

    assign stat_deferred_writes = r_stat_deferred;
    assign stat_forwarded_reads = r_stat_forwarded;
`endif

endmodule

// File: tb/tb_pond_access_arbiter.sv
// Bench for pond_access_arbiter: dual-port memory reference model plus directed scenarios.
module tb_pond_access_arbiter;
    import pond_arb_pkg::*;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;
    localparam int unsigned WORDS = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tile_en;
    logic [CW-1:0] wbuf_count;
    logic          overflow;
`ifdef POND_ACCESS_ARBITER_STATS_EN
    logic [15:0]   stat_deferred_writes;
    logic [15:0]   stat_forwarded_reads;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pond_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    pond_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WBUF_DEPTH(DEPTH)) u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .tile_en              (tile_en),
        .bus                  (bus),
        .wbuf_count           (wbuf_count),
`ifdef POND_ACCESS_ARBITER_STATS_EN
        .stat_deferred_writes (stat_deferred_writes),
        .stat_forwarded_reads (stat_forwarded_reads),
`endif
        .overflow             (overflow)
    );

    // Behavioural single-port SRAM macro: registered read data.
    logic [DW-1:0] sram [WORDS];
    bit            sram_clear = 1'b1;
    always @(posedge clk) begin
        if (sram_clear) begin
            for (int i = 0; i < int'(WORDS); i++) sram[i] <= '0;
        end else if (bus.mem_cen) begin
            if (bus.mem_wen) sram[bus.mem_addr] <= bus.mem_wdata;
            else             bus.mem_rdata      <= sram[bus.mem_addr];
        end
    end

    // Reference model: what software sees is a dual-port memory (golden); the queue tracks buffer occupancy.
    logic [DW-1:0] golden [WORDS];
    int unsigned   q_addr [$];
    logic [DW-1:0] q_data [$];
    bit            m_rdv  = 1'b0;
    bit            m_ovf  = 1'b0;
    logic [DW-1:0] m_rd   = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            q_addr.delete();
            q_data.delete();
            m_rdv = 1'b0;
            m_ovf = 1'b0;
            m_rd  = '0;
            for (int i = 0; i < int'(WORDS); i++) golden[i] = sram[i];
        end else if (tile_en) begin
            m_rdv = bus.rd_valid;
            if (bus.rd_valid) m_rd = golden[bus.rd_addr];
            if (bus.rd_valid) begin
                if (bus.wr_valid) begin
                    if (q_addr.size() == DEPTH) m_ovf = 1'b1;
                    else begin
                        q_addr.push_back(int'(bus.wr_addr));
                        q_data.push_back(bus.wr_data);
                        golden[bus.wr_addr] = bus.wr_data;
                    end
                end
            end else if (q_addr.size() != 0) begin
                q_addr.delete(0);
                q_data.delete(0);
                if (bus.wr_valid) begin
                    q_addr.push_back(int'(bus.wr_addr));
                    q_data.push_back(bus.wr_data);
                    golden[bus.wr_addr] = bus.wr_data;
                end
            end else if (bus.wr_valid) begin
                golden[bus.wr_addr] = bus.wr_data;
            end
        end else begin
            m_rdv = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        logic          exp_cen;
        logic          exp_wen;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_cen = rst_n && tile_en && (bus.rd_valid || (q_addr.size() != 0) || bus.wr_valid);
            exp_wen = 1'b0; exp_addr = '0; exp_wdata = '0;
            if (bus.rd_valid) begin
                exp_addr = bus.rd_addr;
            end else if (q_addr.size() != 0) begin
                exp_wen = 1'b1; exp_addr = AW'(q_addr[0]); exp_wdata = q_data[0];
            end else begin
                exp_wen = 1'b1; exp_addr = bus.wr_addr; exp_wdata = bus.wr_data;
            end
            chk("mem_cen", 32'(bus.mem_cen), 32'(exp_cen));
            if (exp_cen) begin
                chk("mem_wen",  32'(bus.mem_wen),  32'(exp_wen));
                chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
                if (exp_wen) chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
            end
            chk("rd_data_valid", 32'(bus.rd_data_valid), 32'(m_rdv));
            chk("rd_data",       32'(bus.rd_data),       32'(m_rd));
            chk("wbuf_count",    32'(wbuf_count),        q_addr.size());
            chk("overflow",      32'(overflow),          32'(m_ovf));
        end
    end

    task automatic drive(input bit te, input bit wv, input int wa, input int wd,
                         input bit rv, input int ra);
        tile_en      = te;
        bus.wr_valid = wv;
        bus.wr_addr  = AW'(wa);
        bus.wr_data  = DW'(wd);
        bus.rd_valid = rv;
        bus.rd_addr  = AW'(ra);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
    endtask

    // Directed scenarios with hand-computed literal expectations.
    initial begin
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 3, 'h1234, 1'b1, 3);
        drive(1'b1, 1'b1, 3, 'h1234, 1'b1, 3);
        sram_clear = 1'b0;
        chk("reset_cen",   32'(bus.mem_cen),       32'd0);
        chk("reset_valid", 32'(bus.rd_data_valid), 32'd0);
        chk("reset_rd",    32'(bus.rd_data),       32'd0);
        chk("reset_count", 32'(wbuf_count),        32'd0);
        chk("reset_ovf",   32'(overflow),          32'd0);
        rst_n = 1'b1;

        // Direct write then read back from SRAM.
        drive(1'b1, 1'b1, 3, 'hABCD, 1'b0, 0);
        idle();
        drive(1'b1, 1'b0, 0, 0, 1'b1, 3);
        chk("direct_valid", 32'(bus.rd_data_valid), 32'd1);
        chk("direct_rd",    32'(bus.rd_data),       32'hABCD);
        chk("direct_count", 32'(wbuf_count),        32'd0);

        // Deferred write forwarded to the next read, then drained.
        drive(1'b1, 1'b1, 7, 'h1111, 1'b1, 1);
        chk("defer_count", 32'(wbuf_count), 32'd1);
        drive(1'b1, 1'b0, 0, 0, 1'b1, 7);
        chk("fwd_rd",     32'(bus.rd_data), 32'h1111);
        chk("fwd_count",  32'(wbuf_count),  32'd1);
        idle();
        chk("drain_count", 32'(wbuf_count), 32'd0);
        chk("drain_sram7", 32'(sram[7]),    32'h1111);

        // Youngest of two buffered writes to one address.
        drive(1'b1, 1'b1, 5, 'h0001, 1'b1, 0);
        drive(1'b1, 1'b1, 5, 'h0002, 1'b1, 0);
        drive(1'b1, 1'b0, 0, 0, 1'b1, 5);
        chk("young_rd",    32'(bus.rd_data), 32'h0002);
        chk("young_count", 32'(wbuf_count),  32'd2);
        idle();
        idle();
        drive(1'b1, 1'b0, 0, 0, 1'b1, 5);
        chk("young_sram_rd", 32'(bus.rd_data), 32'h0002);
        chk("young_sram5",   32'(sram[5]),     32'h0002);

        // Overflow: five writes into a four-entry buffer under continuous reads.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 10 + i, 'h100 + i, 1'b1, 0);
        chk("ovf_count", 32'(wbuf_count), 32'd4);
        chk("ovf_flag",  32'(overflow),   32'd1);
        repeat (4) idle();
        chk("ovf_drained", 32'(wbuf_count), 32'd0);
        chk("ovf_sticky",  32'(overflow),   32'd1);
        chk("ovf_sram13",  32'(sram[13]),   32'h0103);
        chk("ovf_sram14",  32'(sram[14]),   32'h0000);

        // Same-cycle read and write of one address: read-before-write.
        drive(1'b1, 1'b1, 9, 'h00AA, 1'b0, 0);
        drive(1'b1, 1'b1, 9, 'h00BB, 1'b1, 9);
        chk("coll_old", 32'(bus.rd_data), 32'h00AA);
        drive(1'b1, 1'b0, 0, 0, 1'b1, 9);
        chk("coll_new", 32'(bus.rd_data), 32'h00BB);
        idle();

        // Mid-operation reset discards buffered writes.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 20 + i, 'h2000 + i, 1'b1, 0);
        chk("prerst_count", 32'(wbuf_count), 32'd3);
        rst_n = 1'b0;
        idle();
        chk("midrst_count", 32'(wbuf_count), 32'd0);
        chk("midrst_ovf",   32'(overflow),   32'd0);
        rst_n = 1'b1;
        repeat (3) idle();
        chk("midrst_sram20", 32'(sram[20]), 32'd0);
        chk("midrst_sram22", 32'(sram[22]), 32'd0);

        // tile_en low freezes state and blocks the port.
        drive(1'b1, 1'b1, 25, 'h5555, 1'b1, 0);
        chk("te_count0", 32'(wbuf_count), 32'd1);
        drive(1'b0, 1'b1, 26, 'h6666, 1'b1, 25);
        chk("te_cen",    32'(bus.mem_cen),       32'd0);
        chk("te_count1", 32'(wbuf_count),        32'd1);
        chk("te_valid",  32'(bus.rd_data_valid), 32'd0);
        idle();
        chk("te_drain", 32'(wbuf_count), 32'd0);
        drive(1'b1, 1'b0, 0, 0, 1'b1, 25);
        chk("te_rd25", 32'(bus.rd_data), 32'h5555);
        drive(1'b1, 1'b0, 0, 0, 1'b1, 26);
        chk("te_rd26", 32'(bus.rd_data), 32'h0000);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
